// File: rtl/ym3014_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ym3014_pkg
// Description : Shared frame geometry for the YM3014 serial DAC bus. The
//               serializer and this receiver both take their field offsets
//               from here.
// Revision    : 1.0 - initial release
// ============================================================================
package ym3014_pkg;

    localparam int FRAME_BITS = 18;
    localparam int PAD_BITS   = 5;
    localparam int MANT_BITS  = 10;
    localparam int EXP_BITS   = 3;

    // Field offsets within the frame word (bit 0 is first on the wire)
    localparam int PAD_LSB  = 0;
    localparam int PAD_MSB  = PAD_LSB + PAD_BITS - 1;
    localparam int MANT_LSB = PAD_MSB + 1;
    localparam int MANT_MSB = MANT_LSB + MANT_BITS - 1;
    localparam int EXP_LSB  = MANT_MSB + 1;
    localparam int EXP_MSB  = EXP_LSB + EXP_BITS - 1;

    localparam logic [EXP_BITS-1:0] EXP_RESERVED = 3'd0;

    // Bit counter geometry
    localparam int            CNT_BITS   = 5;
    localparam logic [4:0]    CNT_MAX    = 5'd31;
    localparam logic [4:0]    CNT_FRAME  = 5'(FRAME_BITS);

    // Frame word, MSB first so that member order matches wire order reversed
    typedef struct packed {
        logic [EXP_BITS-1:0]  exp;
        logic [MANT_BITS-1:0] mant;
        logic [PAD_BITS-1:0]  pad;
    } frame_t;

endpackage
`default_nettype wire

// File: rtl/ym3014_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : ym3014_rx_if
// Description : YM3014 DAC bus pins plus the decoded sample stream.
//   iDacClk   : serial bit clock, SD sampled on its rising edge
//   iDacLoad  : frame strobe, falling edge ends a frame
//   iDacSd    : serial data, LSB first
//   oSample   : signed 16-bit linear sample, holds last valid value
//   oValid    : one-cycle strobe when oSample updates
//   oFrameErr : one-cycle strobe when a frame is rejected
//   master    : bus driver / sample consumer side
//   slave     : receiver side
// Revision    : 1.0 - initial release
// ============================================================================
interface ym3014_rx_if;

    logic        iDacClk;
    logic        iDacLoad;
    logic        iDacSd;
    logic [15:0] oSample;
    logic        oValid;
    logic        oFrameErr;

    modport master (
        output iDacClk, iDacLoad, iDacSd,
        input  oSample, oValid, oFrameErr
    );

    modport slave (
        input  iDacClk, iDacLoad, iDacSd,
        output oSample, oValid, oFrameErr
    );

endinterface
`default_nettype wire

// File: rtl/ym3014_decode.sv
`default_nettype none
// ============================================================================
// Module      : ym3014_decode
// Description : Combinational YM3014 floating-point to 16-bit linear
//               conversion.
//   i_mant   : mantissa field f[9:0] (offset-binary)
//   i_exp    : exponent code c[2:0]
//   o_sample : signed 16-bit linear value
// Revision    : 1.0 - initial release
// ============================================================================
module ym3014_decode
    import ym3014_pkg::*;
(
    input  wire logic [MANT_BITS-1:0] i_mant,
    input  wire logic [EXP_BITS-1:0]  i_exp,
    output logic      [15:0]          o_sample
);

    // Offset-binary mantissa to two's complement: flip the top bit
    logic [MANT_BITS-1:0] w_mant_sc;
    logic [15:0]          w_mant_ext;

    assign w_mant_sc  = {~i_mant[MANT_BITS-1], i_mant[MANT_BITS-2:0]};
    assign w_mant_ext = {{(16-MANT_BITS){w_mant_sc[MANT_BITS-1]}}, w_mant_sc};

    // c=7 only ever carries a normalised mantissa, so the shift cannot
    // overflow 16 bits. The reserved code decodes to silence.
    always_comb begin
        o_sample = '0;
        if (i_exp != EXP_RESERVED) begin
            o_sample = w_mant_ext << (i_exp - 3'd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ym3014_rx.sv
`default_nettype none
// ============================================================================
// Module      : ym3014_rx
// Description : YM3014 serial DAC bus receiver. Synchronises the bus pins,
//               deserialises 18-bit frames and converts them to signed
//               16-bit linear PCM.
//   iClk  : system clock, at least 4x the DAC bit clock
//   iRstn : asynchronous active-low reset
//   bus   : ym3014_rx_if.slave (DAC pins in, sample stream out)
// Parameters:
//   SYNC_STAGES : flops per input synchroniser (minimum 2)
// Revision    : 1.0 - initial release
// ============================================================================
module ym3014_rx
    import ym3014_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic   iClk,
    input  wire logic   iRstn,
    ym3014_rx_if.slave  bus
);

    // ------------------------------------------------------------------
    // Input synchronisers with history flops
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic                   r_clk_hist;
    logic                   r_load_hist;

    // Registered edge strobes, with SD captured alongside the CLOCK rise
    logic                   r_clk_rise;
    logic                   r_load_fall;
    logic                   r_sd_cap;

    // CLOCK idles high and LOAD low after reset, so neither chain can
    // present an edge of interest until the pins actually move.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_clk_sync  <= '1;
            r_load_sync <= '0;
            r_sd_sync   <= '0;
            r_clk_hist  <= 1'b1;
            r_load_hist <= 1'b0;
            r_clk_rise  <= 1'b0;
            r_load_fall <= 1'b0;
            r_sd_cap    <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0],  bus.iDacClk};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], bus.iDacLoad};
            r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0],   bus.iDacSd};
            r_clk_hist  <= r_clk_sync[SYNC_STAGES-1];
            r_load_hist <= r_load_sync[SYNC_STAGES-1];
            r_clk_rise  <= r_clk_sync[SYNC_STAGES-1] & ~r_clk_hist;
            r_load_fall <= ~r_load_sync[SYNC_STAGES-1] & r_load_hist;
            r_sd_cap    <= r_sd_sync[SYNC_STAGES-1];
        end
    end

    // ------------------------------------------------------------------
    // Bit capture and frame close
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_BITS-1:0]   r_cnt;
    frame_t                r_word;
    logic                  r_go;
    logic                  r_err_pend;

    // Next-state of shift/count including this cycle's bit, so a LOAD fall
    // coinciding with the last CLOCK rise closes on the completed frame.
    logic [FRAME_BITS-1:0] w_shift_nxt;
    logic [CNT_BITS-1:0]   w_cnt_nxt;

    assign w_shift_nxt = r_clk_rise ? {r_sd_cap, r_shift[FRAME_BITS-1:1]} : r_shift;
    assign w_cnt_nxt   = (r_clk_rise && (r_cnt != CNT_MAX)) ? r_cnt + 5'd1 : r_cnt;

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_word     <= '0;
            r_go       <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_go       <= 1'b0;
            r_err_pend <= 1'b0;
            if (r_load_fall) begin
                r_cnt <= '0;
                if (w_cnt_nxt == CNT_FRAME) begin
                    r_word <= w_shift_nxt;
                    r_go   <= 1'b1;
                end else begin
                    r_err_pend <= 1'b1;
                end
            end
        end
    end

    // Pad bits travel on the wire but carry no information
    logic w_unused_pad;
    assign w_unused_pad = ^r_word.pad;

    // ------------------------------------------------------------------
    // Decode and output registers
    // ------------------------------------------------------------------
    logic [15:0] w_dec_sample;
    logic [15:0] r_sample;
    logic        r_valid;
    logic        r_frame_err;

    ym3014_decode u_decode (
        .i_mant   (r_word.mant),
        .i_exp    (r_word.exp),
        .o_sample (w_dec_sample)
    );

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= r_go;
            r_frame_err <= r_err_pend;
            if (r_go) begin
                r_sample <= w_dec_sample;
            end
        end
    end

    assign bus.oSample   = r_sample;
    assign bus.oValid    = r_valid;
    assign bus.oFrameErr = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ym3014_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ym3014_rx
// Description : Self-checking bench for ym3014_rx. Frames are driven on the
//               DAC pins with 4-iClk bit periods; decoded samples and strobe
//               counts are compared against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ym3014_rx;

    logic clk;
    logic rst_n;

    ym3014_rx_if bus ();

    ym3014_rx #(.SYNC_STAGES(2)) dut (
        .iClk  (clk),
        .iRstn (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;

    // Pulse counters, sampled mid-cycle so each one-cycle strobe counts once
    always @(negedge clk) begin
        if (bus.oValid === 1'b1)    n_valid++;
        if (bus.oFrameErr === 1'b1) n_err++;
    end

    typedef struct {
        logic [2:0]  c;
        logic [9:0]  f;
        logic [4:0]  pad;
        logic [15:0] exp;
    } frame_vec_t;

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp;
    } loop_vec_t;

    frame_vec_t fv [7];
    loop_vec_t  lv [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.iDacSd  = bits[i];
            bus.iDacClk = 1'b0;
            tick(2);
            bus.iDacClk = 1'b1;
            tick(2);
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n);
        bus.iDacLoad = 1'b1;
        tick(1);
        send_bits(bits, n);
        bus.iDacLoad = 1'b0;
        tick(12);
    endtask

    task automatic frame_check(input string name, input logic [17:0] word, input logic [15:0] exp);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame({14'd0, word}, 18);
        check({name, "_valid"}, 32'(n_valid - v0), 32'd1);
        check({name, "_err"},   32'(n_err - e0),   32'd0);
        check({name, "_data"},  {16'd0, bus.oSample}, {16'd0, exp});
    endtask

    // Serializer model: smallest exponent whose shifted value fits 10 bits
    function automatic logic [17:0] encode(input logic [15:0] s);
        logic signed [15:0] v;
        logic signed [15:0] sh;
        logic [9:0]         m;
        logic [2:0]         c;
        logic               found;
        v     = s;
        found = 1'b0;
        c     = 3'd7;
        m     = 10'h200;
        for (int k = 1; k <= 7; k++) begin
            sh = v >>> (k - 1);
            if (!found && sh >= -512 && sh <= 511) begin
                found = 1'b1;
                c     = 3'(k);
                m     = sh[9:0];
            end
        end
        return {c, ~m[9], m[8:0], 5'b0};
    endfunction

    initial begin
        int v0, e0;
        logic [17:0] w;

        fv[0] = '{3'd5, 10'h323, 5'h00, 16'h1230};
        fv[1] = '{3'd1, 10'h1FF, 5'h00, 16'hFFFF};
        fv[2] = '{3'd7, 10'h000, 5'h00, 16'h8000};
        fv[3] = '{3'd0, 10'h155, 5'h00, 16'h0000};
        fv[4] = '{3'd2, 10'h000, 5'h1F, 16'hFC00};
        fv[5] = '{3'd4, 10'h3FF, 5'h0A, 16'h0FF8};
        fv[6] = '{3'd6, 10'h2AB, 5'h00, 16'h1560};

        lv[0] = '{16'h1234, 16'h1230};
        lv[1] = '{16'hFFFF, 16'hFFFF};
        lv[2] = '{16'h8000, 16'h8000};
        lv[3] = '{16'h0000, 16'h0000};

        // Reset
        bus.iDacClk  = 1'b1;
        bus.iDacLoad = 1'b0;
        bus.iDacSd   = 1'b0;
        rst_n        = 1'b0;
        tick(3);
        check("rst_sample", {16'd0, bus.oSample}, 32'd0);
        check("rst_valid",  {31'd0, bus.oValid},  32'd0);
        check("rst_err",    {31'd0, bus.oFrameErr}, 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Latency: LOAD fall first sampled at edge k, strobe at k+4 only
        w = {3'd5, 10'h323, 5'h00};
        bus.iDacLoad = 1'b1;
        tick(1);
        send_bits({14'd0, w}, 18);
        bus.iDacLoad = 1'b0;
        tick(4);
        check("lat_k3_valid", {31'd0, bus.oValid}, 32'd0);
        tick(1);
        check("lat_k4_valid", {31'd0, bus.oValid}, 32'd1);
        check("lat_k4_data",  {16'd0, bus.oSample}, 32'h1230);
        tick(1);
        check("lat_k5_valid", {31'd0, bus.oValid}, 32'd0);
        tick(8);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            frame_check($sformatf("vec%0d", i), {fv[i].c, fv[i].f, fv[i].pad}, fv[i].exp);
        end

        // Loopback through the serializer model
        for (int i = 0; i < 4; i++) begin
            frame_check($sformatf("loop%0d", i), encode(lv[i].din), lv[i].exp);
        end

        // Short and long frames are rejected, sample held
        frame_check("pre_err", {3'd5, 10'h323, 5'h00}, 16'h1230);
        v0 = n_valid;
        e0 = n_err;
        send_frame(32'h0001_2345, 17);
        check("short_err",   32'(n_err - e0),   32'd1);
        check("short_valid", 32'(n_valid - v0), 32'd0);
        check("short_hold",  {16'd0, bus.oSample}, 32'h1230);
        v0 = n_valid;
        e0 = n_err;
        send_frame(32'h01AB_CDEF, 25);
        check("long_err",   32'(n_err - e0),   32'd1);
        check("long_valid", 32'(n_valid - v0), 32'd0);
        check("long_hold",  {16'd0, bus.oSample}, 32'h1230);
        frame_check("post_err", {3'd1, 10'h1FF, 5'h00}, 16'hFFFF);

        // CLOCK rise and LOAD fall together on bit 18
        w  = {3'd7, 10'h000, 5'h00};
        v0 = n_valid;
        e0 = n_err;
        bus.iDacLoad = 1'b1;
        tick(1);
        send_bits({14'd0, w}, 17);
        bus.iDacSd  = w[17];
        bus.iDacClk = 1'b0;
        tick(2);
        bus.iDacClk  = 1'b1;
        bus.iDacLoad = 1'b0;
        tick(12);
        check("simul_valid", 32'(n_valid - v0), 32'd1);
        check("simul_err",   32'(n_err - e0),   32'd0);
        check("simul_data",  {16'd0, bus.oSample}, 32'h8000);

        // Reset mid-frame discards the partial frame
        v0 = n_valid;
        e0 = n_err;
        bus.iDacLoad = 1'b1;
        tick(1);
        send_bits(32'h0001_FFFF, 9);
        bus.iDacClk  = 1'b0;
        bus.iDacLoad = 1'b0;
        bus.iDacSd   = 1'b0;
        rst_n        = 1'b0;
        tick(3);
        check("mid_rst_sample", {16'd0, bus.oSample}, 32'd0);
        rst_n = 1'b1;
        tick(8);
        check("mid_rst_quiet_v", 32'(n_valid - v0), 32'd0);
        check("mid_rst_quiet_e", 32'(n_err - e0),   32'd0);
        frame_check("after_rst", {3'd5, 10'h323, 5'h00}, 16'h1230);
        check("mid_rst_total_v", 32'(n_valid - v0), 32'd1);
        check("mid_rst_total_e", 32'(n_err - e0),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
